memory_stage: RTL and testbench
===============================

# memory_stage

Write-back end of the 5-stage MIPS pipeline. It captures the memory-stage results: ALU result, RAM read data, register-file write enable and memory-to-register select. It then presents the value to write back to the register file, plus its write enable, one clock later. It sits between the data RAM / ALU outputs and the register-file write port.

## Interface
- Parameters:
  - DATA_WIDTH, default 32: width of the data path (ALU result, RAM data, write-back data).
- Ports:
  - clk  input  1  single system clock; all state updates on rising edge.
  - rstn  input  1  reset; asynchronous and active-low. One clock; reset is asynchronous and active-low.
  - iSig_regfile_write  input  1  control: this instruction writes the register file.
  - iSig_MemtoReg  input  1  control: 1 = write back RAM read data, 0 = write back ALU result.
  - iread_from_ram  input  DATA_WIDTH  data read from data RAM for this instruction.
  - ialu_result  input  DATA_WIDTH  ALU result for this instruction.
  - odata2write2regfile  output  DATA_WIDTH  value to write into the register file.
  - oSig_RegfileWrite  output  1  register-file write enable.

## Operation
- Internal pipeline register (MEM/WB latch) holds four fields:
  - regwrite_q (1 bit)
  - memtoreg_q (1 bit)
  - ram_q (DATA_WIDTH)
  - alu_q (DATA_WIDTH)
- On every rising clk edge with rstn=1, all four fields load from the corresponding inputs unconditionally. There is no enable and no stall.
- Outputs are combinational from the latch only, never directly from inputs:
  - odata2write2regfile = memtoreg_q ? ram_q : alu_q
  - oSig_RegfileWrite = regwrite_q
- Data passes through bit-exact: no sign extension, no truncation, no arithmetic.
- When regwrite_q=0, odata2write2regfile still shows the mux result. The consumer must ignore the data when the write enable is low.
- X/Z on the unselected data input must not propagate to odata2write2regfile.

## Timing
- Latency: inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1. Latency is exactly 1 cycle; throughput is one instruction per cycle.
- Reset (rstn=0) clears all latch fields to 0 asynchronously, without waiting for a clock edge. Outputs are therefore odata2write2regfile=0 and oSig_RegfileWrite=0.
- While rstn=0, clock edges are ignored and the outputs hold 0.
- After reset release, the first rising edge with rstn=1 loads the inputs.
- Reset asserted mid-stream discards the in-flight instruction. Its write enable must not appear on the output.
- Simultaneous change of iSig_MemtoReg and data inputs in one cycle: the output reflects the values sampled together at the same edge, never a mix of two cycles.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Stimulus: drive inputs to non-zero values (ialu_result=0xDEADBEEF, iSig_regfile_write=1), then assert rstn=0 between clock edges.
  - Required: outputs go to 0/0 immediately and stay there across 3 clock edges.
- ALU path:
  - Stimulus: rstn=1; iSig_MemtoReg=0, ialu_result=0x00000010, iread_from_ram=0xFFFFFFFF, iSig_regfile_write=1.
  - Required: after the next rising edge, odata2write2regfile=0x00000010 and oSig_RegfileWrite=1. Before that edge, outputs are unchanged.
- RAM path:
  - Stimulus: iSig_MemtoReg=1, iread_from_ram=0x12345678, ialu_result=0x00000004.
  - Required: after the edge, odata2write2regfile=0x12345678.
- Back-to-back:
  - Stimulus: alternate iSig_MemtoReg 0/1 each cycle with distinct data (0xA0, 0xB1, 0xA2, 0xB3).
  - Required: each value appears exactly one cycle later, in order.
- Write-disable:
  - Stimulus: iSig_regfile_write=0, iSig_MemtoReg=0, ialu_result=0x55.
  - Required: after the edge, oSig_RegfileWrite=0 and odata2write2regfile=0x55.
- Mid-stream reset:
  - Stimulus: pulse rstn low for 5 ns between edges while iSig_regfile_write=1.
  - Required: outputs go to 0 immediately. The input values present at the first rising edge after release appear one cycle later.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM/WB pipeline latch and write-back data select
module memory_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  iSig_regfile_write,
    input  logic                  iSig_MemtoReg,
    input  logic [DATA_WIDTH-1:0] iread_from_ram,
    input  logic [DATA_WIDTH-1:0] ialu_result,
    output logic [DATA_WIDTH-1:0] odata2write2regfile,
    output logic                  oSig_RegfileWrite
);

    // MEM/WB latch fields; all four are captured together so the select
    // and both data words always come from the same instruction.
    logic                  regwrite_q;
    logic                  memtoreg_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] alu_q;

    // Capture the memory-stage results every cycle; reset drops the in-flight instruction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            ram_q      <= '0;
            alu_q      <= '0;
        end else begin
            regwrite_q <= iSig_regfile_write;
            memtoreg_q <= iSig_MemtoReg;
            ram_q      <= iread_from_ram;
            alu_q      <= ialu_result;
        end
    end

    // Write-back value is selected purely from latched state, so no input reaches an output
    // combinationally and the unselected word never leaks through.
    always_comb begin
        odata2write2regfile = alu_q;
        if (memtoreg_q) begin
            odata2write2regfile = ram_q;
        end
        oSig_RegfileWrite = regwrite_q;
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for the MEM/WB write-back stage
module tb_memory_stage;

    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          iSig_regfile_write;
    logic          iSig_MemtoReg;
    logic [DW-1:0] iread_from_ram;
    logic [DW-1:0] ialu_result;
    logic [DW-1:0] odata2write2regfile;
    logic          oSig_RegfileWrite;

    memory_stage #(.DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .iSig_regfile_write  (iSig_regfile_write),
        .iSig_MemtoReg       (iSig_MemtoReg),
        .iread_from_ram      (iread_from_ram),
        .ialu_result         (ialu_result),
        .odata2write2regfile (odata2write2regfile),
        .oSig_RegfileWrite   (oSig_RegfileWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // expected {write enable, write-back data}
    logic [DW:0] exp_q[$];
    logic [DW:0] prev_out;

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got we=%0b data=%h, expected we=%0b data=%h",
                     name, act[DW], act[DW-1:0], exp[DW], exp[DW-1:0]);
        end
    endtask

    // Reference behaviour: the instruction written back is the one presented,
    // with the data word chosen by its own MemtoReg bit.
    function automatic logic [DW:0] model(input logic we, input logic mtr,
                                          input logic [DW-1:0] ram, input logic [DW-1:0] alu);
        return {we, (mtr ? ram : alu)};
    endfunction

    // Present one instruction at the falling edge; outputs must still show the previous one.
    task automatic drive(input logic we, input logic mtr,
                         input logic [DW-1:0] ram, input logic [DW-1:0] alu);
        logic [DW:0] e;
        @(negedge clk);
        iSig_regfile_write = we;
        iSig_MemtoReg      = mtr;
        iread_from_ram     = ram;
        ialu_result        = alu;
        e = model(we, mtr, ram, alu);
        exp_q.push_back(e);
        #1;
        chk("hold_before_edge", {oSig_RegfileWrite, odata2write2regfile}, prev_out);
        prev_out = e;
    endtask

    // Monitor: after every rising edge, compare the presented result with the oldest expectation.
    always @(posedge clk) begin
        #2;
        if (rstn && exp_q.size() > 0) begin
            chk("writeback", {oSig_RegfileWrite, odata2write2regfile}, exp_q.pop_front());
        end
    end

    initial begin
        rstn               = 1'b0;
        iSig_regfile_write = 1'b0;
        iSig_MemtoReg      = 1'b0;
        iread_from_ram     = '0;
        ialu_result        = '0;
        prev_out           = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("power_on_reset", {oSig_RegfileWrite, odata2write2regfile}, '0);
        #1 rstn = 1'b1;

        // Reset: load a non-zero instruction, then assert reset between edges.
        drive(1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk("reset_immediate", {oSig_RegfileWrite, odata2write2regfile}, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2 chk("reset_hold", {oSig_RegfileWrite, odata2write2regfile}, '0);
        end
        rstn     = 1'b1;
        prev_out = '0;

        // ALU path, RAM path, back-to-back alternation, write-disable.
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
        drive(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0004);
        drive(1'b1, 1'b0, 32'h0000_00F0, 32'h0000_00A0);
        drive(1'b1, 1'b1, 32'h0000_00B1, 32'h0000_00F1);
        drive(1'b1, 1'b0, 32'h0000_00F2, 32'h0000_00A2);
        drive(1'b1, 1'b1, 32'h0000_00B3, 32'h0000_00F3);
        drive(1'b0, 1'b0, 32'h0000_00AA, 32'h0000_0055);
        drive(1'b1, 1'b0, 32'hxxxx_xxxx, 32'h0BAD_F00D);
        drive(1'b1, 1'b1, 32'hC0FF_EE00, 32'hxxxx_xxxx);

        // Mid-stream reset: 5 ns low pulse between edges with write enable high.
        drive(1'b1, 1'b1, 32'h7777_0001, 32'h8888_0002);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk("midstream_reset_immediate", {oSig_RegfileWrite, odata2write2regfile}, '0);
        #4 rstn = 1'b1;
        #1 chk("midstream_reset_after_release", {oSig_RegfileWrite, odata2write2regfile}, '0);
        prev_out = model(iSig_regfile_write, iSig_MemtoReg, iread_from_ram, ialu_result);
        exp_q.push_back(prev_out);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
        end

        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
